// File: rtl/obi_accel_ctrl.sv
// obi_accel_ctrl: OBI subordinate register block that launches and monitors
// NumChannels accelerator units.
//
// Each channel runs a two-state FSM (idle/busy). A CTRL write starts idle channels,
// done_i completes a busy channel, and an optional watchdog ends a channel that
// runs too long. Completions and timeouts latch pending bits that drive irq_o.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous reset, active low
//   obi_req_i  OBI request (req, a.addr, a.we, a.be, a.wdata, a.aid)
//   obi_rsp_o  OBI response (gnt, rvalid, r.rdata, r.err, r.rid)
//   start_o    one-cycle start pulse per channel
//   done_i     per-channel completion, sampled only while busy
//   match_i    per-channel result flag, valid while done_i is high
//   irq_o      level interrupt, |(IRQ_PEND & IRQ_EN)
//
// Register map (word offset addr[4:2]):
//   0x00 CTRL  0x04 STATUS  0x08 MATCH  0x0C IRQ_EN  0x10 IRQ_PEND (W1C)
//   0x14 TIMEOUT  0x18 TOERR  0x1C reserved (err=1)
module obi_accel_ctrl #(
    parameter int unsigned IdWidth     = 1,
    parameter type         obi_req_t   = struct packed {
        logic req;
        struct packed {
            logic [31:0]        addr;
            logic               we;
            logic [3:0]         be;
            logic [31:0]        wdata;
            logic [IdWidth-1:0] aid;
        } a;
    },
    parameter type         obi_rsp_t   = struct packed {
        logic gnt;
        logic rvalid;
        struct packed {
            logic [31:0]        rdata;
            logic               err;
            logic [IdWidth-1:0] rid;
        } r;
    },
    parameter int unsigned NumChannels = 4,
    parameter int unsigned TimeoutW    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t               obi_req_i,
    output obi_rsp_t               obi_rsp_o,
    output logic [NumChannels-1:0] start_o,
    input  logic [NumChannels-1:0] done_i,
    input  logic [NumChannels-1:0] match_i,
    output logic                   irq_o
);

    localparam int unsigned N = NumChannels;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegStatus  = 3'd1;
    localparam logic [2:0] RegMatch   = 3'd2;
    localparam logic [2:0] RegIrqEn   = 3'd3;
    localparam logic [2:0] RegIrqPend = 3'd4;
    localparam logic [2:0] RegTimeout = 3'd5;
    localparam logic [2:0] RegToerr   = 3'd6;
    localparam logic [2:0] RegRsvd    = 3'd7;

    localparam logic [TimeoutW-1:0] CntMax = '1;
    localparam logic [TimeoutW-1:0] CntOne = TimeoutW'(1);

    logic [N-1:0]        state_q, state_d;
    logic [N-1:0]        start_q, start_d;
    logic [N-1:0]        done_q, done_d;
    logic [N-1:0]        match_q, match_d;
    logic [N-1:0]        irq_en_q, irq_en_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [N-1:0]        toerr_q, toerr_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;
    logic [TimeoutW-1:0] cnt_q [N];
    logic [TimeoutW-1:0] cnt_d [N];

    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [IdWidth-1:0]  rid_q, rid_d;

    logic [2:0]          sel;
    logic                wr_en;
    logic [31:0]         wmask;
    logic [31:0]         wdata_m;
    logic [31:0]         rdata_mux;
    logic [N-1:0]        busy;
    logic [N-1:0]        start_req;
    logic [N-1:0]        w1c;

    // Request decode; byte enables are folded into the write data once here.
    always_comb begin
        sel     = obi_req_i.a.addr[4:2];
        wr_en   = obi_req_i.req & obi_req_i.a.we;
        wmask   = '0;
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{obi_req_i.a.be[b]}};
        end
        wdata_m   = obi_req_i.a.wdata & wmask;
        start_req = (wr_en && sel == RegCtrl) ? wdata_m[N-1:0] : '0;
        w1c       = (wr_en && sel == RegIrqPend) ? wdata_m[N-1:0] : '0;
        for (int c = 0; c < N; c++) begin
            busy[c] = (state_q[c] == StBusy);
        end
    end

    // Channel FSMs and register next state.
    always_comb begin
        state_d   = state_q;
        start_d   = '0;
        timeout_d = timeout_q;
        irq_en_d  = irq_en_q;
        // W1C first so that a same-cycle completion (below) wins.
        pend_d    = pend_q & ~w1c;
        done_d    = done_q & ~w1c;
        match_d   = match_q & ~w1c;
        toerr_d   = toerr_q & ~w1c;
        for (int c = 0; c < N; c++) begin
            cnt_d[c] = cnt_q[c];
        end

        if (wr_en && sel == RegIrqEn) begin
            irq_en_d = (irq_en_q & ~wmask[N-1:0]) | wdata_m[N-1:0];
        end
        if (wr_en && sel == RegTimeout) begin
            timeout_d = (timeout_q & ~wmask[TimeoutW-1:0]) | wdata_m[TimeoutW-1:0];
        end

        for (int c = 0; c < N; c++) begin
            if (state_q[c] == StIdle) begin
                if (start_req[c]) begin
                    state_d[c] = StBusy;
                    start_d[c] = 1'b1;
                    cnt_d[c]   = '0;
                    match_d[c] = 1'b0;
                    toerr_d[c] = 1'b0;
                end
            end else begin
                if (cnt_q[c] != CntMax) begin
                    cnt_d[c] = cnt_q[c] + CntOne;
                end
                if (done_i[c]) begin
                    state_d[c] = StIdle;
                    done_d[c]  = 1'b1;
                    pend_d[c]  = 1'b1;
                    match_d[c] = match_i[c];
                // >= rather than == so a limit lowered below the count fires at once.
                end else if (timeout_q != '0 && cnt_q[c] >= timeout_q - CntOne) begin
                    state_d[c] = StIdle;
                    toerr_d[c] = 1'b1;
                    pend_d[c]  = 1'b1;
                    match_d[c] = 1'b0;
                end
            end
        end
    end

    // Read mux and registered response.
    always_comb begin
        rdata_mux = '0;
        case (sel)
            RegStatus: begin
                rdata_mux[N-1:0]  = busy;
                rdata_mux[16 +: N] = done_q;
            end
            RegMatch:   rdata_mux[N-1:0]        = match_q;
            RegIrqEn:   rdata_mux[N-1:0]        = irq_en_q;
            RegIrqPend: rdata_mux[N-1:0]        = pend_q;
            RegTimeout: rdata_mux[TimeoutW-1:0] = timeout_q;
            RegToerr:   rdata_mux[N-1:0]        = toerr_q;
            default:    rdata_mux               = '0;
        endcase

        rvalid_d = obi_req_i.req;
        rid_d    = obi_req_i.req ? obi_req_i.a.aid : rid_q;
        err_d    = obi_req_i.req && (sel == RegRsvd);
        rdata_d  = (obi_req_i.req && !obi_req_i.a.we) ? rdata_mux : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= '0;
            start_q   <= '0;
            done_q    <= '0;
            match_q   <= '0;
            irq_en_q  <= '0;
            pend_q    <= '0;
            toerr_q   <= '0;
            timeout_q <= '0;
            for (int c = 0; c < N; c++) begin
                cnt_q[c] <= '0;
            end
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            done_q    <= done_d;
            match_q   <= match_d;
            irq_en_q  <= irq_en_d;
            pend_q    <= pend_d;
            toerr_q   <= toerr_d;
            timeout_q <= timeout_d;
            for (int c = 0; c < N; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.err   = err_q;
        obi_rsp_o.r.rid   = rid_q;
        start_o           = start_q;
        irq_o             = |(pend_q & irq_en_q);
    end

    // Address bits outside the word offset and write bits beyond the fields are ignored.
    logic unused_bits;
    assign unused_bits = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0], wdata_m, wmask};

endmodule

// File: tb/tb_obi_accel_ctrl.sv
module tb_obi_accel_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned IdW = 4;

    typedef struct packed {
        logic [31:0]    addr;
        logic           we;
        logic [3:0]     be;
        logic [31:0]    wdata;
        logic [IdW-1:0] aid;
    } tb_a_t;
    typedef struct packed {
        logic  req;
        tb_a_t a;
    } tb_req_t;
    typedef struct packed {
        logic [31:0]    rdata;
        logic           err;
        logic [IdW-1:0] rid;
    } tb_r_t;
    typedef struct packed {
        logic  gnt;
        logic  rvalid;
        tb_r_t r;
    } tb_rsp_t;

    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegStatus  = 3'd1;
    localparam logic [2:0] RegMatch   = 3'd2;
    localparam logic [2:0] RegIrqEn   = 3'd3;
    localparam logic [2:0] RegIrqPend = 3'd4;
    localparam logic [2:0] RegTimeout = 3'd5;
    localparam logic [2:0] RegToerr   = 3'd6;
    localparam logic [2:0] RegRsvd    = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    tb_req_t      req;
    tb_rsp_t      rsp;
    logic [N-1:0] start_o;
    logic [N-1:0] done_i;
    logic [N-1:0] match_i;
    logic         irq;

    obi_accel_ctrl #(
        .IdWidth     (IdW),
        .obi_req_t   (tb_req_t),
        .obi_rsp_t   (tb_rsp_t),
        .NumChannels (N),
        .TimeoutW    (16)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .start_o   (start_o),
        .done_i    (done_i),
        .match_i   (match_i),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]    rdata;
        logic           err;
        logic [IdW-1:0] rid;
        int             due;
        string          name;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_checks = 0;
    int             n_pass = 0;
    logic [IdW-1:0] next_aid = '0;

    // Response scoreboard: every beat must answer exactly one cycle after its grant.
    always @(negedge clk) begin
        if (rsp.rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rvalid at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (mon_e.due !== cyc) $display("FAIL %s latency: rvalid cycle %0d, want %0d", mon_e.name, cyc, mon_e.due);
                else n_pass++;
                n_checks++;
                if (rsp.r.rdata !== mon_e.rdata) $display("FAIL %s rdata: got %h want %h", mon_e.name, rsp.r.rdata, mon_e.rdata);
                else n_pass++;
                n_checks++;
                if (rsp.r.err !== mon_e.err) $display("FAIL %s err: got %b want %b", mon_e.name, rsp.r.err, mon_e.err);
                else n_pass++;
                n_checks++;
                if (rsp.r.rid !== mon_e.rid) $display("FAIL %s rid: got %h want %h", mon_e.name, rsp.r.rid, mon_e.rid);
                else n_pass++;
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            $display("FAIL %s missing_rvalid: none by cycle %0d", mon_e.name, cyc);
        end
    end

    // One beat, starting at a falling edge; returns at the next falling edge so that
    // consecutive calls produce back-to-back beats.
    task automatic bus(input string name, input logic [2:0] word, input logic we,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] addr;
        exp_t        e;
        addr       = $urandom();
        addr[4:2]  = word;
        req.req    = 1'b1;
        req.a.addr = addr;
        req.a.we   = we;
        req.a.be   = be;
        req.a.wdata = wdata;
        req.a.aid  = next_aid;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rid   = next_aid;
        e.due   = cyc + 1;
        e.name  = name;
        sb.push_back(e);
        next_aid = next_aid + 1'b1;
        #1;
        n_checks++;
        if (rsp.gnt !== 1'b1) $display("FAIL %s gnt: got %b want 1", name, rsp.gnt);
        else n_pass++;
        @(negedge clk);
        req.req = 1'b0;
    endtask

    task automatic test_reset();
        req = '0;
        done_i = '0;
        match_i = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({start_o, irq, rsp.rvalid} !== '0) $display("FAIL reset_outputs: start=%h irq=%b rvalid=%b want 0", start_o, irq, rsp.rvalid);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        bus("rst_status", RegStatus, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("rst_match", RegMatch, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("rst_pend", RegIrqPend, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("rst_toerr", RegToerr, 1'b0, 0, 4'hf, 32'h0, 1'b0);
    endtask

    task automatic test_start_done();
        bus("ctrl_wr5", RegCtrl, 1'b1, 32'h5, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (start_o !== 4'h5) $display("FAIL start_pulse: got %h want 5", start_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (start_o !== 4'h0) $display("FAIL start_one_cycle: got %h want 0", start_o);
        else n_pass++;
        repeat (8) @(negedge clk);
        done_i = 4'h1;
        match_i = 4'h1;
        @(negedge clk);
        done_i = '0;
        match_i = '0;
        bus("status_after_done", RegStatus, 1'b0, 0, 4'hf, 32'h0001_0004, 1'b0);
        bus("match_after_done", RegMatch, 1'b0, 0, 4'hf, 32'h1, 1'b0);
        bus("pend_after_done", RegIrqPend, 1'b0, 0, 4'hf, 32'h1, 1'b0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_irq();
        bus("irqen_wr1", RegIrqEn, 1'b1, 32'h1, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq);
        else n_pass++;
        bus("pend_w1c1", RegIrqPend, 1'b1, 32'h1, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq);
        else n_pass++;
        bus("status_after_w1c", RegStatus, 1'b0, 0, 4'hf, 32'h4, 1'b0);
        bus("match_after_w1c", RegMatch, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("irqen_rd", RegIrqEn, 1'b0, 0, 4'hf, 32'h1, 1'b0);
    endtask

    task automatic test_busy_restart();
        bus("ctrl_wr4_busy", RegCtrl, 1'b1, 32'h4, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (start_o !== 4'h0) $display("FAIL restart_no_pulse: got %h want 0", start_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (start_o !== 4'h0) $display("FAIL restart_no_pulse_late: got %h want 0", start_o);
        else n_pass++;
        done_i = 4'h4;
        match_i = 4'h4;
        bus("pend_w1c4_with_done", RegIrqPend, 1'b1, 32'h4, 4'hf, 32'h0, 1'b0);
        done_i = '0;
        match_i = '0;
        bus("pend_set_wins", RegIrqPend, 1'b0, 0, 4'hf, 32'h4, 1'b0);
        bus("match_ch2", RegMatch, 1'b0, 0, 4'hf, 32'h4, 1'b0);
        bus("status_ch2_done", RegStatus, 1'b0, 0, 4'hf, 32'h0004_0000, 1'b0);
        bus("pend_w1c4", RegIrqPend, 1'b1, 32'h4, 4'hf, 32'h0, 1'b0);
        bus("status_clear", RegStatus, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("match_clear", RegMatch, 1'b0, 0, 4'hf, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        int waited;
        bus("irqen_wr_hi", RegIrqEn, 1'b1, 32'hffff_fff2, 4'hf, 32'h0, 1'b0);
        bus("irqen_unused_bits", RegIrqEn, 1'b0, 0, 4'hf, 32'h2, 1'b0);
        bus("timeout_wr8", RegTimeout, 1'b1, 32'h8, 4'hf, 32'h0, 1'b0);
        bus("timeout_rd8", RegTimeout, 1'b0, 0, 4'hf, 32'h8, 1'b0);
        bus("ctrl_wr2", RegCtrl, 1'b1, 32'h2, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (start_o !== 4'h2) $display("FAIL start_ch1: got %h want 2", start_o);
        else n_pass++;
        waited = 0;
        while (irq !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited !== 8) $display("FAIL timeout_busy_cycles: got %0d want 8", waited);
        else n_pass++;
        bus("toerr_ch1", RegToerr, 1'b0, 0, 4'hf, 32'h2, 1'b0);
        bus("pend_ch1", RegIrqPend, 1'b0, 0, 4'hf, 32'h2, 1'b0);
        bus("match_ch1_to", RegMatch, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("status_after_to", RegStatus, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("timeout_be1", RegTimeout, 1'b1, 32'hffff_ffff, 4'b0010, 32'h0, 1'b0);
        bus("timeout_be_rd", RegTimeout, 1'b0, 0, 4'hf, 32'h0000_ff08, 1'b0);
        bus("timeout_off", RegTimeout, 1'b1, 32'h0, 4'hf, 32'h0, 1'b0);
        bus("pend_w1c2", RegIrqPend, 1'b1, 32'h2, 4'hf, 32'h0, 1'b0);
        bus("toerr_cleared", RegToerr, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_after_to_clear: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_reserved();
        bus("rsvd_rd", RegRsvd, 1'b0, 0, 4'hf, 32'h0, 1'b1);
        bus("rsvd_wr", RegRsvd, 1'b1, 32'hdead_beef, 4'hf, 32'h0, 1'b1);
        bus("ctrl_rd", RegCtrl, 1'b0, 0, 4'hf, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        bus("b2b_irqen", RegIrqEn, 1'b0, 0, 4'hf, 32'h2, 1'b0);
        bus("b2b_toerr", RegToerr, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("b2b_rsvd", RegRsvd, 1'b0, 0, 4'hf, 32'h0, 1'b1);
        bus("b2b_status", RegStatus, 1'b0, 0, 4'hf, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus("ctrl_wr3", RegCtrl, 1'b1, 32'h3, 4'hf, 32'h0, 1'b0);
        n_checks++;
        if (start_o !== 4'h3) $display("FAIL start_ch01: got %h want 3", start_o);
        else n_pass++;
        @(negedge clk);
        done_i = 4'h2;
        @(negedge clk);
        done_i = '0;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_before_reset: got %b want 1", irq);
        else n_pass++;
        bus("ctrl_wr4", RegCtrl, 1'b1, 32'h4, 4'hf, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({start_o, irq, rsp.rvalid} !== '0) $display("FAIL reset_mid_outputs: start=%h irq=%b rvalid=%b want 0", start_o, irq, rsp.rvalid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        done_i = 4'hf;
        match_i = 4'hf;
        @(negedge clk);
        done_i = '0;
        match_i = '0;
        bus("status_post_rst", RegStatus, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("pend_idle_done", RegIrqPend, 1'b0, 0, 4'hf, 32'h0, 1'b0);
        bus("irqen_post_rst", RegIrqEn, 1'b0, 0, 4'hf, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_done();
        test_irq();
        test_busy_restart();
        test_timeout();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
